// File: rtl/count_check_pkg.sv
// Shared types and helpers for the count sequence checker.
package count_check_pkg;

  // Checker FSM states with fixed encodings.
  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StAcquire = 2'b01,
    StLocked  = 2'b10
  } state_e;

  // Increment modulo 2^width; callers size-cast the result to their bus width.
  function automatic logic [63:0] wrap_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] mask;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (value + 64'd1) & mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable and asynchronous clear.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  // Count up on inc, holding once all-ones is reached.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != {Width{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_sequence_checker.sv
// Watches a free-running count bus and verifies each valid sample is the previous plus one.
// Optional feature: define COUNT_CHECK_CLEAR_TOLERANT_EN to treat a locked sample of 0 as an
// upstream clear (restart_pulse) rather than a mismatch.
module count_sequence_checker
  import count_check_pkg::*;
#(
  parameter int unsigned N        = 7,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [N:0]       count_in,
  input  logic             count_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             wrap_pulse,
  output logic             restart_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [N:0]       expected
);

  localparam int unsigned W    = N + 1;
  localparam int unsigned RunW = $clog2(LOCK_CNT + 1);

  state_e          state_q, state_d;
  logic [N:0]      expected_q, expected_d;
  logic [RunW-1:0] run_q, run_d;
  logic            locked_q, locked_d;
  logic            mismatch_q, mismatch_d;
  logic            wrap_q, wrap_d;
  logic            restart_d;
  logic            match;
  logic [N:0]      count_inc, expected_inc;

  assign count_inc    = W'(wrap_inc(64'(count_in), W));
  assign expected_inc = W'(wrap_inc(64'(expected_q), W));
  assign match        = (count_in == expected_q);

  // Next-state and pulse decode; everything holds unless a valid sample arrives.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    run_d      = run_q;
    locked_d   = locked_q;
    mismatch_d = 1'b0;
    wrap_d     = 1'b0;
    restart_d  = 1'b0;
    if (count_valid) begin
      case (state_q)
        StIdle: begin
          expected_d = count_inc;
          run_d      = '0;
          state_d    = StAcquire;
        end
        StAcquire: begin
          if (match) begin
            run_d      = run_q + 1'b1;
            expected_d = expected_inc;
            if (run_q == RunW'(LOCK_CNT - 1)) begin
              state_d  = StLocked;
              locked_d = 1'b1;
            end
          end else begin
            expected_d = count_inc;
            run_d      = '0;
          end
        end
        StLocked: begin
          if (match) begin
            expected_d = expected_inc;
            wrap_d     = (count_in == '0);
`ifdef COUNT_CHECK_CLEAR_TOLERANT_EN
          end else if (count_in == '0) begin
            // Upstream counter was cleared: resynchronise without losing lock.
            restart_d  = 1'b1;
            expected_d = W'(1);
`endif
          end else begin
            mismatch_d = 1'b1;
            expected_d = count_inc;
            run_d      = '0;
            locked_d   = 1'b0;
            state_d    = StAcquire;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= StIdle;
      expected_q <= '0;
      run_q      <= '0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      run_q      <= run_d;
      locked_q   <= locked_d;
      mismatch_q <= mismatch_d;
      wrap_q     <= wrap_d;
    end
  end

`ifdef COUNT_CHECK_CLEAR_TOLERANT_EN
  logic restart_q;

  // Registered restart pulse.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      restart_q <= 1'b0;
    end else begin
      restart_q <= restart_d;
    end
  end

  assign restart_pulse = restart_q;
`else
  logic unused_restart;
  assign unused_restart = restart_d;
  assign restart_pulse  = 1'b0;
`endif

  sat_counter #(
    .Width(ERR_W)
  ) u_err_counter (
    .clock(clock),
    .clear(clear),
    .inc  (mismatch_d),
    .count(err_count)
  );

  assign locked     = locked_q;
  assign mismatch   = mismatch_q;
  assign wrap_pulse = wrap_q;
  assign expected   = expected_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Randomised and directed bench for count_sequence_checker against a behavioural model.
module tb_count_sequence_checker;

  localparam int N        = 7;
  localparam int LOCK_CNT = 4;
  localparam int ERR_W    = 2;
  localparam int MODULUS  = 1 << (N + 1);
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic             clock = 1'b0;
  logic             clear = 1'b0;
  logic [N:0]       count_in = '0;
  logic             count_valid = 1'b0;
  logic             locked, mismatch, wrap_pulse, restart_pulse;
  logic [ERR_W-1:0] err_count;
  logic [N:0]       expected;

  count_sequence_checker #(
    .N       (N),
    .LOCK_CNT(LOCK_CNT),
    .ERR_W   (ERR_W)
  ) dut (
    .clock        (clock),
    .clear        (clear),
    .count_in     (count_in),
    .count_valid  (count_valid),
    .locked       (locked),
    .mismatch     (mismatch),
    .wrap_pulse   (wrap_pulse),
    .restart_pulse(restart_pulse),
    .err_count    (err_count),
    .expected     (expected)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  // Model: mode 0 = unsynchronised, 1 = hunting for a run, 2 = verified.
  int m_mode, m_exp, m_run, m_err;
  bit m_locked, m_mis, m_wrap, m_rst;

  task automatic check(input string tag, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_run = 0; m_err = 0;
    m_locked = 0; m_mis = 0; m_wrap = 0; m_rst = 0;
  endtask

  task automatic model_sample(input bit v, input int c);
    m_mis = 0; m_wrap = 0; m_rst = 0;
    if (!v) return;
    if (m_mode == 0) begin
      m_exp = (c + 1) % MODULUS; m_run = 0; m_mode = 1;
    end else if (c == m_exp) begin
      m_exp = (m_exp + 1) % MODULUS;
      if (m_mode == 1) begin
        m_run++;
        if (m_run == LOCK_CNT) begin m_mode = 2; m_locked = 1; end
      end else if (c == 0) m_wrap = 1;
    end else if (m_mode == 1) begin
      m_exp = (c + 1) % MODULUS; m_run = 0;
    end else begin
`ifdef COUNT_CHECK_CLEAR_TOLERANT_EN
      if (c == 0) begin
        m_rst = 1; m_exp = 1;
        return;
      end
`endif
      m_mis = 1;
      if (m_err < ERR_MAX) m_err++;
      m_exp = (c + 1) % MODULUS; m_run = 0; m_locked = 0; m_mode = 1;
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".locked"},   32'(locked),        32'(m_locked));
    check({ctx, ".mismatch"}, 32'(mismatch),      32'(m_mis));
    check({ctx, ".wrap"},     32'(wrap_pulse),    32'(m_wrap));
    check({ctx, ".restart"},  32'(restart_pulse), 32'(m_rst));
    check({ctx, ".err"},      32'(err_count),     m_err);
    check({ctx, ".expected"}, 32'(expected),      m_exp);
  endtask

  // Apply one cycle of input, then compare just after the edge.
  task automatic step(input string ctx, input bit v, input int c);
    count_valid = v;
    count_in    = (N + 1)'(c);
    @(posedge clock);
    model_sample(v, c);
    #1;
    check_all(ctx);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #2;
    model_reset();
    check_all("clear");
    @(negedge clock);
    clear = 1'b0;
  endtask

  initial begin
    int src;
    model_reset();
    do_clear();

    // Lock acquisition from 0.
    for (int i = 0; i <= 4; i++) step("lock", 1, i);
    check("lock.locked_final", 32'(locked), 1);

    // Wrap through all-ones.
    do_clear();
    for (int i = 250; i <= 255; i++) step("wrap", 1, i);
    step("wrap0", 1, 0);
    check("wrap.pulse_at_0", 32'(wrap_pulse), 1);
    step("wrap1", 1, 1);

    // Skip while locked, then relock.
    for (int i = 2; i <= 10; i++) step("pre_skip", 1, i);
    step("skip", 1, 12);
    check("skip.mismatch", 32'(mismatch), 1);
    for (int i = 13; i <= 16; i++) step("relock", 1, i);

    // Upstream clear while locked with expected=50.
    for (int i = 17; i <= 49; i++) step("pre_zero", 1, i);
    step("zero", 1, 0);
    for (int i = 1; i <= 5; i++) step("post_zero", 1, i);

    // Five separate skips saturate the 2-bit error counter.
    src = 6;
    for (int k = 0; k < 5; k++) begin
      src = src + 2;
      for (int i = 0; i < 5; i++) step("sat", 1, (src + i) % MODULUS);
      src = src + 4;
    end
    check("sat.err_final", 32'(err_count), ERR_MAX);

    // Gaps: count_valid low with changing data holds everything.
    for (int i = 0; i < 3; i++) step("gap", 0, $urandom_range(0, MODULUS - 1));

    // Async clear mid-cycle while locked with err_count=2.
    do_clear();
    src = 100;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) step("pre_aclr", 1, src + i);
      src = src + 7;
    end
    for (int i = 0; i < 5; i++) step("pre_aclr", 1, src + i);
    check("aclr.err_before", 32'(err_count), 2);
    clear = 1'b1;
    #2;
    model_reset();
    check("aclr.locked", 32'(locked), 0);
    check("aclr.err", 32'(err_count), 0);
    check("aclr.expected", 32'(expected), 0);
    @(negedge clock);
    clear = 1'b0;
    step("post_aclr", 1, 77);

    // Random traffic: mostly counting, with gaps, jumps and zeros.
    src = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit v;
      r = int'($urandom_range(0, 99));
      v = (r >= 12);
      if (v) begin
        if (r < 16) src = int'($urandom_range(0, MODULUS - 1));
        else if (r < 19) src = 0;
        else src = (src + 1) % MODULUS;
        step("rand", 1, src);
      end else begin
        step("rand_gap", 0, int'($urandom_range(0, MODULUS - 1)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
